// File: rtl/go_cursor_ctrl.sv
// Cursor and move-entry controller for an N x N Go board: skips occupied points
// while moving, validates commits, supports passes and locks between turns.
module go_cursor_ctrl #(
    parameter int                     BOARD_N   = 9,
    parameter int                     COORD_W   = 5,
    parameter bit                     WRAP      = 1'b1,
    parameter logic [2*COORD_W-1:0]   PASS_CODE = '1
) (
    input  logic                             clk_in,
    input  logic                             reset,
    input  logic                             my_turn,
    input  logic                             pass_sw,
    input  logic                             up,
    input  logic                             down,
    input  logic                             left,
    input  logic                             right,
    input  logic                             make_move,
    input  logic [2*BOARD_N*BOARD_N-1:0]     board_flat,
    output logic [2*COORD_W-1:0]             cursor_out,
    output logic                             locked,
    output logic                             move_ready,
    output logic [2*COORD_W-1:0]             move_out,
    output logic                             move_reject
);

    typedef enum logic [1:0] {S_LOCKED, S_IDLE, S_SEEK, S_COMMIT} state_t;
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;
    // One extra bit so that -1 and BOARD_N are distinguishable from on-board values.
    typedef logic signed [COORD_W:0] scoord_t;

    localparam scoord_t LAST = scoord_t'(BOARD_N - 1);
    localparam scoord_t ZERO = '0;

    state_t                 state_q, state_d;
    dir_t                   dir_q, dir_d;
    logic                   armed_q, armed_d;
    logic [COORD_W-1:0]     cur_row_q, cur_row_d, cur_col_q, cur_col_d;
    scoord_t                probe_row_q, probe_row_d, probe_col_q, probe_col_d;
    logic [2*COORD_W-1:0]   move_out_q, move_out_d;
    logic                   move_ready_q, move_ready_d;
    logic                   move_reject_q, move_reject_d;
    logic                   locked_q, locked_d;

    scoord_t start_row, start_col, pr_w, pc_w;
    logic    off_board, hit_start, probe_empty, cur_empty;

    function automatic logic is_empty(input logic [2*BOARD_N*BOARD_N-1:0] b,
                                      input int r, input int c);
        int idx;
        idx = r * BOARD_N + c;
        if (idx < 0 || idx >= BOARD_N * BOARD_N) idx = 0;
        return b[2*idx +: 2] == 2'b00;
    endfunction

    function automatic scoord_t step_row(input scoord_t r, input dir_t d);
        case (d)
            D_UP:    return r + scoord_t'(1);
            D_DOWN:  return r - scoord_t'(1);
            default: return r;
        endcase
    endfunction

    function automatic scoord_t step_col(input scoord_t c, input dir_t d);
        case (d)
            D_RIGHT: return c + scoord_t'(1);
            D_LEFT:  return c - scoord_t'(1);
            default: return c;
        endcase
    endfunction

    always_comb begin
        state_d       = state_q;
        dir_d         = dir_q;
        armed_d       = armed_q;
        cur_row_d     = cur_row_q;
        cur_col_d     = cur_col_q;
        probe_row_d   = probe_row_q;
        probe_col_d   = probe_col_q;
        move_out_d    = move_out_q;
        move_ready_d  = 1'b0;
        move_reject_d = 1'b0;

        start_row = scoord_t'({1'b0, cur_row_q});
        start_col = scoord_t'({1'b0, cur_col_q});

        pr_w = probe_row_q;
        pc_w = probe_col_q;
        if (probe_row_q < ZERO)      pr_w = LAST;
        else if (probe_row_q > LAST) pr_w = ZERO;
        if (probe_col_q < ZERO)      pc_w = LAST;
        else if (probe_col_q > LAST) pc_w = ZERO;

        off_board   = (probe_row_q < ZERO) || (probe_row_q > LAST) ||
                      (probe_col_q < ZERO) || (probe_col_q > LAST);
        hit_start   = (pr_w == start_row) && (pc_w == start_col);
        probe_empty = is_empty(board_flat, int'(pr_w), int'(pc_w));
        cur_empty   = is_empty(board_flat, int'(cur_row_q), int'(cur_col_q));

        case (state_q)
            S_LOCKED: begin
                if (my_turn && armed_q) begin
                    state_d = S_IDLE;
                    armed_d = 1'b0;
                end
            end
            S_IDLE: begin
                if (make_move) begin
                    if (pass_sw) begin
                        state_d      = S_COMMIT;
                        move_out_d   = PASS_CODE;
                        move_ready_d = 1'b1;
                    end else if (cur_empty) begin
                        state_d      = S_COMMIT;
                        move_out_d   = {cur_row_q, cur_col_q};
                        move_ready_d = 1'b1;
                    end else begin
                        move_reject_d = 1'b1;
                    end
                end else if (up || down || left || right) begin
                    if (up)        dir_d = D_UP;
                    else if (down) dir_d = D_DOWN;
                    else if (left) dir_d = D_LEFT;
                    else           dir_d = D_RIGHT;
                    probe_row_d = step_row(start_row, dir_d);
                    probe_col_d = step_col(start_col, dir_d);
                    state_d     = S_SEEK;
                end
            end
            S_SEEK: begin
                if (off_board && !WRAP) begin
                    state_d = S_IDLE;
                end else if (hit_start) begin
                    state_d = S_IDLE;
                end else if (probe_empty) begin
                    cur_row_d = pr_w[COORD_W-1:0];
                    cur_col_d = pc_w[COORD_W-1:0];
                    state_d   = S_IDLE;
                end else begin
                    probe_row_d = step_row(pr_w, dir_q);
                    probe_col_d = step_col(pc_w, dir_q);
                end
            end
            default: begin
                state_d = S_LOCKED;
                armed_d = 1'b0;
            end
        endcase

        // Losing the turn overrides everything still pending this cycle.
        if (!my_turn) begin
            state_d       = S_LOCKED;
            armed_d       = 1'b1;
            cur_row_d     = cur_row_q;
            cur_col_d     = cur_col_q;
            move_out_d    = move_out_q;
            move_ready_d  = 1'b0;
            move_reject_d = 1'b0;
        end

        locked_d = (state_d == S_LOCKED);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q       <= S_LOCKED;
            dir_q         <= D_UP;
            armed_q       <= 1'b1;
            cur_row_q     <= '0;
            cur_col_q     <= '0;
            probe_row_q   <= '0;
            probe_col_q   <= '0;
            move_out_q    <= '0;
            move_ready_q  <= 1'b0;
            move_reject_q <= 1'b0;
            locked_q      <= 1'b1;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            armed_q       <= armed_d;
            cur_row_q     <= cur_row_d;
            cur_col_q     <= cur_col_d;
            probe_row_q   <= probe_row_d;
            probe_col_q   <= probe_col_d;
            move_out_q    <= move_out_d;
            move_ready_q  <= move_ready_d;
            move_reject_q <= move_reject_d;
            locked_q      <= locked_d;
        end
    end

    assign cursor_out  = {cur_row_q, cur_col_q};
    assign locked      = locked_q;
    assign move_ready  = move_ready_q;
    assign move_out    = move_out_q;
    assign move_reject = move_reject_q;

endmodule
